dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port data memory: one write port (clocked), one combinational read path, read data tri-stated when not reading.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug master.
- Accepts held req/ack transactions, serialises them onto the memory bus, and registers the read data back to the winner.
- Selectable round-robin or fixed priority; fixed priority has a starvation guard.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters onto one single-port data memory.
//   Port 0 is the pipeline MEM stage. Port 1 is the loader/debug master.
//   Each transaction is a held req/ack handshake. The memory is accessed in
//   the cycle after the winner is latched, and the ack follows one cycle later.
//   Ports:
//     clk_i, rst_i                   clock (rising edge), async active-high reset
//     reqN_i/weN_i/addrN_i/wdataN_i  requester N command, held until ackN_o
//     ackN_o/rdataN_o                one-cycle completion pulse, registered read data
//     mem_write_d/mem_read_d/addr_d/write_data_d/read_data_q  memory bus
//     busy_o                         high while the memory access cycle is active
//     grant_o                        port being served or acked
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif
`ifndef WIDTH
`define WIDTH 32
`endif

module dmem_arbiter #(
  parameter int AW         = `ADDRWIDTH,
  parameter int DW         = `WIDTH,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_WAIT   = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          ack0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack1_o,
  output logic [DW-1:0] rdata1_o,
  output logic          mem_write_d,
  output logic          mem_read_d,
  output logic [AW-1:0] addr_d,
  output logic [DW-1:0] write_data_d,
  input  logic [DW-1:0] read_data_q,
  output logic          busy_o,
  output logic          grant_o
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DONE} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t        r_state, w_next;
  logic          r_grant, r_last, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [3:0]    r_wait;
  logic          w_elig0, w_elig1, w_latch, w_win;

  // The port being acked is blind for one cycle, so a requester still
  // holding req during its ack is not served twice for the same command.
  always_comb begin
    w_elig0 = req0_i && !(r_state == S_DONE && !r_grant);
    w_elig1 = req1_i && !(r_state == S_DONE &&  r_grant);
    w_latch = (r_state != S_SERVE) && (w_elig0 || w_elig1);
    if (w_elig0 && w_elig1)
      w_win = FIXED_PRIO ? (r_wait >= WAIT_LIM) : !r_last;
    else
      w_win = w_elig1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_latch) w_next = S_SERVE;
      S_SERVE: w_next = S_DONE;
      S_DONE:  w_next = w_latch ? S_SERVE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus strobes come from state and latched command only, so reset drops
  // them combinationally and no write can land on the next edge.
  assign busy_o       = (r_state == S_SERVE);
  assign mem_write_d  = (r_state == S_SERVE) &&  r_we;
  assign mem_read_d   = (r_state == S_SERVE) && !r_we;
  assign addr_d       = r_addr;
  assign write_data_d = r_wdata;
  assign ack0_o       = (r_state == S_DONE) && !r_grant;
  assign ack1_o       = (r_state == S_DONE) &&  r_grant;
  assign rdata0_o     = r_rdata0;
  assign rdata1_o     = r_rdata1;
  assign grant_o      = r_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;     // port 0 wins the first tie
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_wait   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_grant <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? we1_i    : we0_i;
        r_addr  <= w_win ? addr1_i  : addr0_i;
        r_wdata <= w_win ? wdata1_i : wdata0_i;
        // Starvation counter only moves on a grant decision.
        if (w_win || !req1_i)
          r_wait <= 4'd0;
        else if (r_wait != 4'hF)
          r_wait <= r_wait + 4'd1;
      end
      if (r_state == S_SERVE && !r_we) begin
        if (r_grant) r_rdata1 <= read_data_q;
        else         r_rdata0 <= read_data_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Round-robin instance
  logic        a_req0, a_we0, a_req1, a_we1;
  logic [7:0]  a_addr0, a_addr1, a_ad;
  logic [31:0] a_wd0, a_wd1, a_rd0, a_rd1, a_wdo;
  logic        a_ack0, a_ack1, a_mw, a_mr, a_busy, a_grant;
  wire  [31:0] a_rdq;
  logic [31:0] mem_a [256];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;

  always @(posedge clk)
    if (pl_en)     mem_a[pl_a] <= pl_d;
    else if (a_mw) mem_a[a_ad] <= a_wdo;
  assign a_rdq = a_mr ? mem_a[a_ad] : 'z;

  dmem_arbiter #(.AW(8), .DW(32), .FIXED_PRIO(1'b0), .MAX_WAIT(4)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .wdata0_i(a_wd0),
    .ack0_o(a_ack0), .rdata0_o(a_rd0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .wdata1_i(a_wd1),
    .ack1_o(a_ack1), .rdata1_o(a_rd1),
    .mem_write_d(a_mw), .mem_read_d(a_mr), .addr_d(a_ad), .write_data_d(a_wdo),
    .read_data_q(a_rdq), .busy_o(a_busy), .grant_o(a_grant));

  // Fixed-priority instance, read-only traffic
  logic        f_req0, f_req1;
  logic [7:0]  f_addr0, f_addr1, f_ad;
  logic [31:0] f_rd0, f_rd1, f_wdo;
  logic        f_ack0, f_ack1, f_mw, f_mr, f_busy, f_grant;
  wire  [31:0] f_rdq;
  logic [31:0] mem_b [256];
  initial for (int i = 0; i < 256; i++) mem_b[i] = 32'hB000_0000 | 32'(i);
  assign f_rdq = f_mr ? mem_b[f_ad] : 'z;

  dmem_arbiter #(.AW(8), .DW(32), .FIXED_PRIO(1'b1), .MAX_WAIT(4)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .req0_i(f_req0), .we0_i(1'b0), .addr0_i(f_addr0), .wdata0_i(32'h0),
    .ack0_o(f_ack0), .rdata0_o(f_rd0),
    .req1_i(f_req1), .we1_i(1'b0), .addr1_i(f_addr1), .wdata1_i(32'h0),
    .ack1_o(f_ack1), .rdata1_o(f_rd1),
    .mem_write_d(f_mw), .mem_read_d(f_mr), .addr_d(f_ad), .write_data_d(f_wdo),
    .read_data_q(f_rdq), .busy_o(f_busy), .grant_o(f_grant));

  logic [31:0] ref_m [16];      // contents of 0x80..0x8F as the requesters see them
  logic [31:0] exp_rd0, exp_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flags"}, {26'd0, a_ack0, a_ack1, a_mw, a_mr, a_busy, a_grant}, 32'd0);
    chk({tag, "_addr"}, a_ad, 32'd0);
    chk({tag, "_wdata"}, a_wdo, 32'd0);
    chk({tag, "_rd0"}, a_rd0, 32'd0);
    chk({tag, "_rd1"}, a_rd1, 32'd0);
  endtask

  // One requester issuing random reads/writes; port p owns addresses of parity p
  // in 0x80..0x8F, so each port's view of memory is its own program order.
  task automatic run_port(input int p);
    for (int n = 0; n < 12; n++) begin
      logic        we;
      logic [7:0]  ad;
      logic [31:0] wd;
      logic        got;
      we = 1'($urandom_range(0, 1));
      ad = 8'h80 + 8'(2 * $urandom_range(0, 7) + p);
      wd = $urandom;
      if (p == 0) begin a_req0 = 1; a_we0 = we; a_addr0 = ad; a_wd0 = wd; end
      else        begin a_req1 = 1; a_we1 = we; a_addr1 = ad; a_wd1 = wd; end
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
        @(negedge clk);
        got = (p == 0) ? a_ack0 : a_ack1;
      end
      chk("rnd_ack_timeout", {31'd0, got}, 32'd1);
      if (got && !we) chk("rnd_rdata", (p == 0) ? a_rd0 : a_rd1, ref_m[ad[3:0]]);
      if (got && we) ref_m[ad[3:0]] = wd;
      if ($urandom_range(0, 2) == 0) begin
        if (p == 0) a_req0 = 0; else a_req1 = 0;
        @(negedge clk);
      end
    end
    if (p == 0) a_req0 = 0; else a_req1 = 0;
  endtask

  initial begin
    logic [31:0] v1, v2;
    logic [7:0]  bb_a [3];
    logic [31:0] bb_v [3];
    logic        gr [6];
    int          ng;

    rst = 1'b1; pl_en = 0; pl_a = 0; pl_d = 0;
    a_req0 = 0; a_we0 = 0; a_addr0 = 0; a_wd0 = 0;
    a_req1 = 0; a_we1 = 0; a_addr1 = 0; a_wd1 = 0;
    f_req0 = 0; f_req1 = 0; f_addr0 = 0; f_addr1 = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk_reset_outs("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_idle");

    // Port 0 write 0x05 then read it back
    a_req0 = 1; a_we0 = 1; a_addr0 = 8'h05; a_wd0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_serve_mw", a_mw, 1); chk("wr_serve_mr", a_mr, 0);
    chk("wr_addr", a_ad, 32'h05); chk("wr_wdata", a_wdo, 32'hDEADBEEF);
    chk("wr_early_ack", a_ack0, 0);
    @(negedge clk);
    chk("wr_ack0", a_ack0, 1); chk("wr_done_mw", a_mw, 0); chk("wr_ack1", a_ack1, 0);
    a_req0 = 0;
    @(negedge clk);
    chk("wr_idle_ack0", a_ack0, 0); chk("wr_idle_mw", a_mw, 0);
    chk("wr_mem", mem_a[8'h05], 32'hDEADBEEF);
    a_req0 = 1; a_we0 = 0;
    @(negedge clk);
    chk("rd_serve_mr", a_mr, 1); chk("rd_addr", a_ad, 32'h05);
    @(negedge clk);
    chk("rd_ack0", a_ack0, 1); chk("rd_rdata0", a_rd0, 32'hDEADBEEF);
    chk("rd_ack1", a_ack1, 0); chk("rd_rdata1", a_rd1, 32'd0);
    a_req0 = 0;
    @(negedge clk);

    // Round-robin with both ports holding reads. Port 0 was granted last,
    // so the first tie goes to port 1, then grants alternate.
    v1 = $urandom; v2 = $urandom;
    preload(8'h01, v1); preload(8'h02, v2);
    a_req0 = 1; a_we0 = 0; a_addr0 = 8'h01;
    a_req1 = 1; a_we1 = 0; a_addr1 = 8'h02;
    for (int i = 0; i < 8; i++) begin
      int p;
      @(negedge clk);
      p = 1 ^ ((i / 2) & 1);
      chk("rr_busy", a_busy, (i % 2 == 0));
      if (i % 2 == 0) begin
        chk("rr_grant", a_grant, p);
        chk("rr_addr", a_ad, (p == 1) ? 2 : 1);
        chk("rr_mr", a_mr, 1);
      end else begin
        chk("rr_ack0", a_ack0, (p == 0));
        chk("rr_ack1", a_ack1, (p == 1));
        if (p == 0) chk("rr_rdata0", a_rd0, v1);
        else        chk("rr_rdata1", a_rd1, v2);
      end
    end
    a_req0 = 0; a_req1 = 0;
    exp_rd0 = v1; exp_rd1 = v2;
    @(negedge clk);

    // Port 0 back-to-back reads, address changed during each ack
    bb_a[0] = 8'h03; bb_a[1] = 8'h04; bb_a[2] = 8'h06;
    for (int j = 0; j < 3; j++) begin bb_v[j] = $urandom; preload(bb_a[j], bb_v[j]); end
    a_req0 = 1; a_we0 = 0; a_addr0 = bb_a[0];
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_mr", a_mr, (i % 3 == 0));
      if (i % 3 == 0) chk("b2b_addr", a_ad, bb_a[i / 3]);
      if (i % 3 == 1) begin
        chk("b2b_ack", a_ack0, 1);
        chk("b2b_rdata", a_rd0, bb_v[i / 3]);
        if (i / 3 < 2) a_addr0 = bb_a[i / 3 + 1];
        else           a_req0 = 0;
      end
    end
    exp_rd0 = bb_v[2];

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_strobes", {29'd0, a_mr, a_mw, a_busy}, 32'd0);
      chk("idle_rd0", a_rd0, exp_rd0);
      chk("idle_rd1", a_rd1, exp_rd1);
    end

    // Fixed priority: port 0 holds req, port 1 requests only while the FSM
    // idles, so four port-0 grants build the wait count before port 1 wins.
    f_req0 = 1; f_addr0 = 8'h03; f_req1 = 1; f_addr1 = 8'h07;
    ng = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(negedge clk);
      if (f_busy) begin gr[ng] = f_grant; ng++; end
      f_req1 = !f_busy && !f_ack0 && !f_ack1;
    end
    f_req0 = 0; f_req1 = 0;
    chk("fx_grants_seen", ng, 6);
    for (int j = 0; j < 6; j++) chk("fx_grant_seq", {31'd0, gr[j]}, (j == 4));
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("fx_rdata0", f_rd0, 32'hB000_0003);
    chk("fx_rdata1", f_rd1, 32'hB000_0007);

    // Reset pulse during a write's memory cycle
    preload(8'h0A, 32'hA5A5_0F0F);
    a_req0 = 1; a_we0 = 1; a_addr0 = 8'h0A; a_wd0 = 32'h12345678;
    @(negedge clk);
    chk("rst_pre_mw", a_mw, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_mw", a_mw, 0);
    chk("rst_async_busy", a_busy, 0);
    @(negedge clk);
    chk("rst_mem_kept", mem_a[8'h0A], 32'hA5A5_0F0F);
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_replay_mw", a_mw, 1); chk("rst_replay_addr", a_ad, 32'h0A);
    @(negedge clk);
    chk("rst_replay_ack", a_ack0, 1);
    chk("rst_replay_mem", mem_a[8'h0A], 32'h12345678);
    a_req0 = 0; a_we0 = 0;
    @(negedge clk);

    // Randomized concurrent traffic against the reference memory
    for (int j = 0; j < 16; j++) begin
      ref_m[j] = $urandom;
      preload(8'h80 + 8'(j), ref_m[j]);
    end
    fork
      run_port(0);
      run_port(1);
    join
    @(negedge clk); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
